// File: rtl/mem_readback_streamer_pkg.sv
// mem_rb_pkg: shared FSM state type and checksum width for the readback streamer
package mem_rb_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;
    localparam int CHECKSUM_W = 32;
endpackage

// File: rtl/mem_readback_streamer_if.sv
// mem_readback_streamer_if: RAM read port plus valid/ready output stream
interface mem_readback_streamer_if #(
    parameter int WID_MEM = 18,
    parameter int ADDR_W  = 12
);
    logic [ADDR_W-1:0]  raddr;
    logic [WID_MEM-1:0] rdata;
    logic [WID_MEM-1:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    modport master (output raddr, m_data, m_valid, m_last, input rdata, m_ready);
    modport slave  (input raddr, m_data, m_valid, m_last, output rdata, m_ready);
endinterface

// File: rtl/mem_readback_streamer_fifo.sv
// rb_fifo: small synchronous first-word-fall-through FIFO; output reads zero when empty
module rb_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic          pop_ok, push_ok;
    assign valid   = count != '0;
    assign dout    = valid ? mem[rd] : '0;
    assign pop_ok  = pop && valid;
    assign push_ok = push && (count < CW'(DEPTH) || pop_ok);
    // storage write; contents need no reset because the output is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr] <= din;
    end
    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr <= wr + PW'(1);
            if (pop_ok) rd <= rd + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: sweeps a registered-read RAM and streams every word with a running checksum
module mem_readback_streamer
    import mem_rb_pkg::*;
#(
    parameter int WID_MEM    = 18,
    parameter int DEPTH_MEM  = 4096,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CHECKSUM_W-1:0] checksum,
    mem_readback_streamer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_MEM - 1);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              v1, v2, l1, l2;
    logic [CW-1:0]     fifo_count;
    logic [WID_MEM:0]  head;
    logic [SW-1:0]     need, have;
    logic              kick, issue, pop;
    assign kick  = state == IDLE && start;
    assign pop   = bus.m_valid && bus.m_ready;
    // a slot is claimed for every read in the RAM pipeline, so the FIFO can never overflow
    assign need  = SW'(fifo_count) + SW'(v1) + SW'(v2) + SW'(1);
    assign have  = SW'(FIFO_DEPTH) + SW'(pop);
    assign issue = state == SCAN && need <= have;
    assign bus.m_last = head[WID_MEM];
    assign bus.m_data = head[WID_MEM-1:0];
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    // next state and status outputs; DRAIN exits as soon as the final pop empties the buffer
    always_comb begin
        state_nx = state;
        busy     = state == SCAN || state == DRAIN;
        done     = state == FIN;
        case (state)
            IDLE:    if (start) state_nx = DEPTH_MEM == 1 ? DRAIN : SCAN;
            SCAN:    if (issue && ptr == LAST) state_nx = DRAIN;
            DRAIN:   if (!v1 && !v2 && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end
    // read issue: the accepting start edge already presents address 0, then one address per issue
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            bus.raddr <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            l1    <= 1'b0;
            l2    <= 1'b0;
        end else begin
            v2 <= v1;
            l2 <= l1;
            v1 <= kick || issue;
            l1 <= kick ? DEPTH_MEM == 1 : issue && ptr == LAST;
            if (kick) begin
                bus.raddr <= '0;
                ptr       <= ADDR_W'(1);
            end else if (issue) begin
                bus.raddr <= ptr;
                ptr       <= ptr + ADDR_W'(1);
            end
        end
    end
    // checksum of transferred words, cleared when a sweep starts and held afterwards
    always_ff @(posedge clk) begin
        if (reset || kick) checksum <= '0;
        else if (pop) checksum <= checksum + CHECKSUM_W'(bus.m_data);
    end
    rb_fifo #(.W(WID_MEM + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset || kick),
        .push  (v2),
        .din   ({l2, bus.rdata}),
        .pop   (pop),
        .dout  (head),
        .valid (bus.m_valid),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_mem_readback_streamer.sv
// tb_mem_readback_streamer: vector-driven sweeps against a RAM-image reference model
module tb_mem_readback_streamer;
    localparam int DEPTH = 4096;
    typedef struct {
        int          pat;
        int          ready_pct;
        int          stall;
        bit          dstart;
        logic [31:0] exp_sum;
    } vec_t;
    logic        clk = 0;
    logic        reset, start, busy, done;
    logic [31:0] checksum;
    logic [17:0] ram [DEPTH];
    logic [17:0] expq [$];
    logic [31:0] model_sum;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs [6];
    mem_readback_streamer_if #(.WID_MEM(18), .ADDR_W(12)) bus ();
    mem_readback_streamer #(.WID_MEM(18), .DEPTH_MEM(DEPTH), .ADDR_W(12), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .bus      (bus)
    );
    always #5 clk = ~clk;
    // RAM with one-cycle registered read
    always @(posedge clk) bus.rdata <= ram[bus.raddr];
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic fill(input int pat);
        expq.delete();
        model_sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = pat == 0 ? 18'(i) : pat == 1 ? 18'h3FFFF : 18'($urandom);
            expq.push_back(ram[i]);
            model_sum += 32'(ram[i]);
        end
    endtask
    task automatic sweep(input vec_t v);
        int          idx, cyc, first_v, last_c, done_c, dones, maxc;
        logic [31:0] exp_sum, r10;
        logic [17:0] prev_d, w;
        bit          prev_stall;
        fill(v.pat);
        exp_sum = v.pat == 2 ? model_sum : v.exp_sum;
        idx = 0; cyc = 0; first_v = -1; last_c = -1; done_c = -1; dones = 0; maxc = 0;
        prev_stall = 0; prev_d = 0; r10 = 0;
        start = 1;
        tick;
        start = 0;
        check("busy_after_start", busy, 1);
        check("raddr_after_start", bus.raddr, 0);
        while (cyc < 20000 && dones == 0) begin
            bus.m_ready = cyc < v.stall ? 1'b0 : $urandom_range(99) < v.ready_pct;
            start = v.dstart && (cyc == 10 || (bus.m_valid && bus.m_last));
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, prev_d);
            end
            if (bus.m_valid && first_v < 0) first_v = cyc;
            if (bus.m_valid && bus.m_ready) begin
                if (expq.size() > 0) begin
                    w = expq.pop_front();
                    check("word_data", bus.m_data, w);
                    check("word_last", bus.m_last, idx == DEPTH - 1);
                end else check("extra_word", idx, DEPTH - 1);
                if (bus.m_last) last_c = cyc;
                idx++;
            end
            if (done) begin
                dones++;
                done_c = cyc;
            end
            if (int'(dut.u_fifo.count) > maxc) maxc = int'(dut.u_fifo.count);
            if (cyc == 10) r10 = 32'(bus.raddr);
            if (v.stall >= 100 && cyc == 99) begin
                check("stall_raddr_held", bus.raddr, r10);
                check("stall_fifo_full", 32'(dut.u_fifo.count), 4);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d = bus.m_data;
            tick;
            cyc++;
        end
        start = 0;
        bus.m_ready = 1;
        check("done_seen", dones, 1);
        check("word_count", idx, DEPTH);
        check("first_latency", first_v, 2);
        check("done_after_last", done_c, last_c + 1);
        check("fifo_overflow", maxc > 4, 0);
        if (v.ready_pct == 100 && v.stall == 0) check("sweep_cycles", last_c, DEPTH + 1);
        check("checksum", checksum, exp_sum);
        for (int i = 0; i < 3; i++) begin
            check("idle_busy", busy, 0);
            check("idle_valid", bus.m_valid, 0);
            check("idle_done", done, 0);
            tick;
        end
        check("checksum_held", checksum, exp_sum);
    endtask
    initial begin
        int  n;
        bit  quiet;
        vecs[0] = '{0, 100, 0,   1'b0, 32'd8386560};
        vecs[1] = '{0, 30,  0,   1'b0, 32'd8386560};
        vecs[2] = '{0, 100, 100, 1'b0, 32'd8386560};
        vecs[3] = '{0, 100, 0,   1'b1, 32'd8386560};
        vecs[4] = '{1, 100, 0,   1'b0, 32'd1073737728};
        vecs[5] = '{2, 50,  0,   1'b0, 32'd0};
        reset = 1;
        start = 0;
        bus.m_ready = 0;
        fill(0);
        repeat (3) tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", bus.m_valid, 0);
        check("rst_last", bus.m_last, 0);
        check("rst_data", bus.m_data, 0);
        check("rst_raddr", bus.raddr, 0);
        check("rst_checksum", checksum, 0);
        reset = 0;
        tick;
        for (int i = 0; i < 6; i++) sweep(vecs[i]);
        fill(0);
        start = 1;
        tick;
        start = 0;
        bus.m_ready = 1;
        n = 0;
        for (int c = 0; c < 2000 && n < 1000; c++) begin
            if (bus.m_valid && bus.m_ready) n++;
            tick;
        end
        check("mid_words", n, 1000);
        reset = 1;
        tick;
        reset = 0;
        check("mid_rst_valid", bus.m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_checksum", checksum, 0);
        quiet = 1;
        for (int c = 0; c < 10; c++) begin
            if (bus.m_valid || done || busy) quiet = 0;
            tick;
        end
        check("mid_rst_quiet", quiet, 1);
        reset = 1;
        start = 1;
        tick;
        reset = 0;
        start = 0;
        check("rst_beats_start", busy, 0);
        tick;
        check("rst_beats_start_valid", bus.m_valid, 0);
        sweep(vecs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
